// File: rtl/pea_pkg.sv
// Shared types and default widths for the execute-stage accumulation counter.
// Global PEA state, per-channel phase encoding, counter widths.
package pea_pkg;

  localparam int N_BITS_TC_REG    = 8;
  localparam int N_BITS_START_REG = 4;
  localparam int NBIT_II          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    EXEC   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DELAY = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2
  } acc_phase_t;

endpackage

// File: rtl/acc_counter_ch.sv
// One accumulation channel: start delay, II divider and trip counter.
// Count changes reg_start+reg_II+3 cycles after activation, then every reg_II+1 cycles.
module acc_counter_ch
  import pea_pkg::*;
#(
  parameter int TC_W    = N_BITS_TC_REG,
  parameter int START_W = N_BITS_START_REG,
  parameter int II_W    = NBIT_II
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               active_i,
  input  logic               stall_i,
  input  logic               clr_i,
  input  logic               mode_i,
  input  logic [START_W-1:0] reg_start_i,
  input  logic [II_W-1:0]    reg_ii_i,
  input  logic [TC_W-1:0]    reg_tc_i,
  output logic               tick_o,
  output logic [TC_W-1:0]    count_o,
  output logic               end_o,
  output logic               end_d1_o,
  output logic               done_o
);

  acc_phase_t         phase_q;
  logic [START_W-1:0] start_q;
  logic [II_W-1:0]    ii_q;
  logic               tick_q;
  logic [TC_W-1:0]    count_q;
  logic               end_d1_q;

  assign tick_o   = tick_q & ~stall_i;
  assign count_o  = count_q;
  assign end_o    = (count_q == reg_tc_i);
  assign end_d1_o = end_d1_q;
  assign done_o   = (phase_q == DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q  <= DELAY;
      start_q  <= '0;
      ii_q     <= '0;
      tick_q   <= 1'b0;
      count_q  <= '0;
      end_d1_q <= 1'b0;
    end else if (clr_i) begin
      phase_q  <= DELAY;
      start_q  <= '0;
      ii_q     <= '0;
      tick_q   <= 1'b0;
      count_q  <= '0;
      end_d1_q <= end_o;
    end else if (stall_i) begin
      end_d1_q <= end_d1_q;
    end else if (!active_i) begin
      // count survives deactivation so a re-entered stream resumes where it was
      phase_q  <= DELAY;
      start_q  <= '0;
      ii_q     <= '0;
      tick_q   <= 1'b0;
      end_d1_q <= end_o;
    end else begin
      end_d1_q <= end_o;
      case (phase_q)
        DELAY: begin
          if (start_q == reg_start_i) begin
            phase_q <= RUN;
            start_q <= '0;
          end else begin
            start_q <= start_q + 1'b1;
          end
        end
        RUN: begin
          ii_q   <= (ii_q == reg_ii_i) ? '0 : ii_q + 1'b1;
          tick_q <= (ii_q == reg_ii_i);
          if (tick_q) begin
            if (count_q != reg_tc_i) begin
              count_q <= count_q + 1'b1;
            end else if (!mode_i) begin
              count_q <= '0;
            end else begin
              phase_q <= DONE;
              tick_q  <= 1'b0;
              ii_q    <= '0;
            end
          end
        end
        DONE: begin
          tick_q <= 1'b0;
        end
        default: begin
          phase_q <= DELAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/accumulation_counter_mc.sv
// N_CH independent accumulation counters sharing global state and stall.
// all_done_o asserts once every enabled channel has finished its one-shot run.
module accumulation_counter_mc
  import pea_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int TC_W    = N_BITS_TC_REG,
  parameter int START_W = N_BITS_START_REG,
  parameter int II_W    = NBIT_II
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  state_t                  state_i,
  input  logic [N_CH-1:0]         ch_en_i,
  input  logic [N_CH-1:0]         mode_i,
  input  logic                    stall_i,
  input  logic [N_CH-1:0]         clr_i,
  input  logic [N_CH*START_W-1:0] reg_start_i,
  input  logic [N_CH*II_W-1:0]    reg_II_i,
  input  logic [N_CH*TC_W-1:0]    reg_tc_i,
  output logic [N_CH-1:0]         tick_o,
  output logic [N_CH*TC_W-1:0]    count_o,
  output logic [N_CH-1:0]         end_o,
  output logic [N_CH-1:0]         end_d1_o,
  output logic [N_CH-1:0]         done_o,
  output logic                    all_done_o
);

  logic exec_w;

  assign exec_w = (state_i == EXEC);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    acc_counter_ch #(
      .TC_W    (TC_W),
      .START_W (START_W),
      .II_W    (II_W)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .active_i    (exec_w & ch_en_i[c]),
      .stall_i     (stall_i),
      .clr_i       (clr_i[c]),
      .mode_i      (mode_i[c]),
      .reg_start_i (reg_start_i[c*START_W +: START_W]),
      .reg_ii_i    (reg_II_i[c*II_W +: II_W]),
      .reg_tc_i    (reg_tc_i[c*TC_W +: TC_W]),
      .tick_o      (tick_o[c]),
      .count_o     (count_o[c*TC_W +: TC_W]),
      .end_o       (end_o[c]),
      .end_d1_o    (end_d1_o[c]),
      .done_o      (done_o[c])
    );
  end

  // disabled channels never block completion
  assign all_done_o = &(done_o | ~ch_en_i);

endmodule

// File: tb/tb_accumulation_counter_mc.sv
// Directed bench for accumulation_counter_mc: timing, stall, clear, re-entry, reset, all_done.
module tb_accumulation_counter_mc;
  import pea_pkg::*;

  localparam int N_CH = 4;
  localparam int TC_W = N_BITS_TC_REG;
  localparam int SW   = N_BITS_START_REG;
  localparam int IW   = NBIT_II;

  logic                 clk = 1'b0;
  logic                 rst;
  state_t               state;
  logic [N_CH-1:0]      ch_en, mode, clr;
  logic                 stall;
  logic [N_CH*SW-1:0]   reg_start;
  logic [N_CH*IW-1:0]   reg_ii;
  logic [N_CH*TC_W-1:0] reg_tc;
  logic [N_CH-1:0]      tick, end_w, end_d1, done;
  logic [N_CH*TC_W-1:0] count;
  logic                 all_done;

  int n_pass = 0;
  int n_fail = 0;
  int cyc    = 0;

  accumulation_counter_mc #(.N_CH(N_CH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .state_i     (state),
    .ch_en_i     (ch_en),
    .mode_i      (mode),
    .stall_i     (stall),
    .clr_i       (clr),
    .reg_start_i (reg_start),
    .reg_II_i    (reg_ii),
    .reg_tc_i    (reg_tc),
    .tick_o      (tick),
    .count_o     (count),
    .end_o       (end_w),
    .end_d1_o    (end_d1),
    .done_o      (done),
    .all_done_o  (all_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s t%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic cfg(input int c, input int s, input int ii, input int tc);
    reg_start[c*SW +: SW]  = s[SW-1:0];
    reg_ii[c*IW +: IW]     = ii[IW-1:0];
    reg_tc[c*TC_W +: TC_W] = tc[TC_W-1:0];
  endtask

  function automatic logic [31:0] cnt(input int c);
    return 32'(count[c*TC_W +: TC_W]);
  endfunction

  // Leaves the bench #1 after the edge that sampled rst=1, with rst released (cycle t0).
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int          cnt0_s1 [24] = '{0,0,0,0,0,0,1,1,2,2,3,3,0,0,1,1,2,0,0,0,0,0,0,1};
  int          cnt0_s3 [18] = '{0,0,0,0,0,0,1,1,1,1,1,2,2,3,3,3,0,0};
  logic [31:0] m_tick, m_end, m_end_d1, m_done, m_all;
  int          exp_c;

  initial begin
    rst   = 1'b1;
    state = IDLE;
    ch_en = 4'b0011;
    mode  = 4'b0010;
    clr   = '0;
    stall = 1'b0;
    cfg(0, 2, 1, 3);
    cfg(1, 0, 0, 2);
    cfg(2, 3, 2, 4);
    cfg(3, 1, 1, 5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_end_d1", 32'(end_d1), 0);
    chk("rst_all_done", 32'(all_done), 0);

    // ch0 continuous start=2 II=1 tc=3, ch1 one-shot start=0 II=0 tc=2, clr ch0 at t16
    @(posedge clk); #1;
    rst   = 1'b0;
    state = EXEC;
    m_tick   = 32'h0040_AAA0;
    m_end    = 32'h0000_0C00;
    m_end_d1 = 32'h0000_1800;
    m_done   = 32'h00FF_FFE0;
    for (int k = 0; k < 24; k++) begin
      cyc = k;
      clr = (k == 16) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      chk("s1_tick0", 32'(tick[0]), 32'(m_tick[k]));
      chk("s1_count0", cnt(0), cnt0_s1[k]);
      chk("s1_end0", 32'(end_w[0]), 32'(m_end[k]));
      chk("s1_end_d1_0", 32'(end_d1[0]), 32'(m_end_d1[k]));
      exp_c = (k < 3) ? 0 : (k == 3) ? 1 : 2;
      chk("s2_count1", cnt(1), exp_c);
      chk("s2_tick1", 32'(tick[1]), (k >= 2 && k <= 4) ? 1 : 0);
      chk("s2_done1", 32'(done[1]), 32'(m_done[k]));
      @(posedge clk); #1;
    end
    clr = '0;
    chk("s1_all_done", 32'(all_done), 0);

    // ch0 alone, stall during t6..t8 and t14
    ch_en = 4'b0001;
    do_reset();
    m_tick   = 32'h0002_9420;
    m_end    = 32'h0000_E000;
    m_end_d1 = 32'h0001_C000;
    for (int k = 0; k < 18; k++) begin
      cyc = k;
      stall = (k >= 6 && k <= 8) || (k == 14);
      @(negedge clk);
      chk("s3_tick0", 32'(tick[0]), 32'(m_tick[k]));
      chk("s3_count0", cnt(0), cnt0_s3[k]);
      chk("s3_end0", 32'(end_w[0]), 32'(m_end[k]));
      chk("s3_end_d1_0", 32'(end_d1[0]), 32'(m_end_d1[k]));
      @(posedge clk); #1;
    end
    stall = 1'b0;

    // leave EXEC at t6 (count=1) for two cycles, re-enter at t8, reset at t15
    do_reset();
    m_tick = 32'h0000_A020;
    for (int k = 0; k < 16; k++) begin
      cyc = k;
      state = (k == 6 || k == 7) ? IDLE : EXEC;
      rst   = (k == 15);
      @(negedge clk);
      chk("s5_tick0", 32'(tick[0]), 32'(m_tick[k]));
      exp_c = (k < 6) ? 0 : (k < 14) ? 1 : 2;
      chk("s5_count0", cnt(0), exp_c);
      @(posedge clk); #1;
    end
    cyc = 16;
    rst = 1'b0;
    @(negedge clk);
    chk("s5_rst_count", 32'(count), 0);
    chk("s5_rst_tick", 32'(tick), 0);
    chk("s5_rst_end0", 32'(end_w[0]), 0);
    chk("s5_rst_end_d1", 32'(end_d1), 0);
    chk("s5_rst_done", 32'(done), 0);

    // ch0 and ch2 one-shot, ch1/ch3 disabled
    @(posedge clk); #1;
    ch_en = 4'b0101;
    mode  = 4'b0101;
    cfg(0, 0, 0, 1);
    cfg(1, 0, 0, 5);
    cfg(2, 1, 0, 2);
    cfg(3, 0, 0, 5);
    do_reset();
    m_done = 32'h0000_01F0;
    m_all  = 32'h0000_01C0;
    for (int k = 0; k < 9; k++) begin
      cyc = k;
      @(negedge clk);
      chk("s6_done0", 32'(done[0]), 32'(m_done[k]));
      chk("s6_all_done", 32'(all_done), 32'(m_all[k]));
      chk("s6_disabled_tick", 32'(tick & 4'b1010), 0);
      @(posedge clk); #1;
    end
    chk("s6_count0", cnt(0), 1);
    chk("s6_count2", cnt(2), 2);
    chk("s6_count1", cnt(1), 0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule

// File: doc/accumulation_counter_mc.md
Name: accumulation_counter_mc

Overview:
Multi-channel, parametrised successor of the PEA accumulation counter. Each channel runs its own start delay, II divider and trip-count counter, and adds a per-channel one-shot/continuous mode, a global stall, a synchronous clear, and per-channel tick/done/count outputs. The block sits in the execute stage alongside the PEA and flags accumulation boundaries (end_o/end_d1_o) for N_CH independent accumulation streams.

Parameters:
N_CH, 4, number of independent channels
TC_W, N_BITS_TC_REG, trip-count counter width
START_W, N_BITS_START_REG, start-delay counter width
II_W, NBIT_II, initiation-interval counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
state_i  in  state_t  global state; channels run only while state_i == EXEC
ch_en_i  in  N_CH  per-channel enable
mode_i  in  N_CH  0 = continuous (wrap), 1 = one-shot (stop at tc)
stall_i  in  1  global freeze of all channel state
clr_i  in  N_CH  synchronous per-channel clear
reg_start_i  in  N_CH x START_W  start delay per channel
reg_II_i  in  N_CH x II_W  II per channel (tick period = II+1)
reg_tc_i  in  N_CH x TC_W  terminal count per channel
tick_o  out  N_CH  count-enable pulse
count_o  out  N_CH x TC_W  current count
end_o  out  N_CH  count == reg_tc (combinational)
end_d1_o  out  N_CH  end_o delayed one cycle
done_o  out  N_CH  one-shot channel finished
all_done_o  out  1  AND over channels of (done_o | ~ch_en_i)

Behaviour:
- Reset (rst_i = 1, synchronous): phase = DELAY, start_cnt = ii_cnt = count = 0, tick_q = 0, end_d1_o = 0, done = 0. Reset overrides every other input.
- Per-channel phases: DELAY, RUN, DONE (acc_phase_t).
- Channel inactive (state_i != EXEC or ch_en_i = 0): phase -> DELAY, start_cnt = ii_cnt = tick_q = 0, done -> 0. count holds its value.
- clr_i[c]: same effect as inactive, and count -> 0. Priority: rst_i > clr_i > stall_i > normal operation.
- DELAY: start_cnt increments each cycle. When start_cnt == reg_start, next cycle is RUN and start_cnt -> 0. DELAY therefore lasts reg_start+1 cycles.
- RUN: ii_cnt counts 0..reg_II and wraps. tick_q is registered and set on the cycle after ii_cnt == reg_II. tick_o = tick_q & ~stall_i.
- Count update on tick_o:
  - count != reg_tc: count + 1.
  - count == reg_tc, continuous mode: count -> 0.
  - count == reg_tc, one-shot mode: count holds at reg_tc, phase -> DONE.
- DONE: no further ticks, done_o = 1. Leaves DONE only via inactive, clr_i or rst_i.
- Latency: if t0 is the first active cycle, the first count change is visible at t0 + reg_start + reg_II + 3. Subsequent changes come every reg_II+1 cycles.
- stall_i: freezes phase, start_cnt, ii_cnt, tick_q and count. Outputs keep their values, except tick_o is forced to 0.
- Compares are equality only. If reg_tc is reprogrammed below the current count, count wraps modulo 2^TC_W before matching. Config inputs are sampled live, not latched.
- end_o = (count == reg_tc) in every phase. end_d1_o is registered from end_o.

Decomposition:
- pea_pkg: acc_phase_t enum {DELAY, RUN, DONE}; default widths N_BITS_TC_REG, N_BITS_START_REG, NBIT_II.
- Sub-module acc_counter_ch: one channel (phase FSM, start/II/tc counters, end_d1 register), instantiated N_CH times via generate.
- Top level: fan-out of state_i/stall_i and the all_done_o reduction.

Test Plan:
- Ch0, start=2, II=1, tc=3, continuous, EXEC from t0 -> tick_o at t5, t7, t9, t11; count 1@t6, 2@t8, 3@t10, 0@t12; end_o high t10-t11, end_d1_o high t11-t12.
- Ch1, start=0, II=0, tc=2, one-shot -> count 1@t3, 2@t4, done_o high from t5, count stays 2, no tick after t4.
- Same setup as scenario 1, stall_i high t6-t8 -> every event after t6 shifts 3 cycles later; tick_o low during stall; count unchanged t6-t8.
- clr_i[0] pulse while count=2 -> count 0 next cycle, phase DELAY; restart timing matches t0 = clear cycle + 1.
- state_i leaves EXEC mid-RUN with count=1, then re-enters -> count still 1, start delay rerun, next increment at reg_start + reg_II + 3 after re-entry; rst_i mid-run -> all outputs 0 next cycle.
- ch_en = 4'b0101, ch0 and ch2 one-shot -> all_done_o high only after both done_o are high; disabled channels never tick.
